// File: rtl/seg7_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : seg7_pkg
// Purpose  : Shared constants and types for the 7-segment capture path.
//            It holds the segment patterns for the digits 0-9 and for blank,
//            the reserved BCD codes, and the output handshake state type.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package seg7_pkg;

  // Segment order is {a,b,c,d,e,f,g}. Bit 6 is segment a and bit 0 is
  // segment g. A segment is lit when its bit is 1.
  localparam logic [6:0] SEG_0     = 7'h7E;
  localparam logic [6:0] SEG_1     = 7'h30;
  localparam logic [6:0] SEG_2     = 7'h6D;
  localparam logic [6:0] SEG_3     = 7'h79;
  localparam logic [6:0] SEG_4     = 7'h33;
  localparam logic [6:0] SEG_5     = 7'h5B;
  localparam logic [6:0] SEG_6     = 7'h5F;
  localparam logic [6:0] SEG_7     = 7'h70;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h7B;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Codes that are not decimal digits.
  localparam logic [3:0] CODE_BLANK = 4'hF;
  localparam logic [3:0] CODE_ERR   = 4'hE;

  // Output frame buffer state.
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } out_state_t;

endpackage : seg7_pkg
`default_nettype wire

// File: rtl/seg7_decode.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : seg7_decode
// Purpose  : Combinational decoder from a 7-segment pattern to a BCD code.
//            A blank pattern decodes to CODE_BLANK and is not an error.
//            Any pattern that is not a digit and not blank decodes to
//            CODE_ERR with err set.
// Ports    : seg   in  7  segment pattern {a,b,c,d,e,f,g}
//            code  out 4  decoded code
//            err   out 1  pattern is not a digit or blank
// Revision : 1.0 - initial release
// ============================================================================
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] code,
  output logic       err
);

  always_comb begin
    code = CODE_ERR;
    err  = 1'b1;
    case (seg)
      SEG_0:     begin code = 4'd0;       err = 1'b0; end
      SEG_1:     begin code = 4'd1;       err = 1'b0; end
      SEG_2:     begin code = 4'd2;       err = 1'b0; end
      SEG_3:     begin code = 4'd3;       err = 1'b0; end
      SEG_4:     begin code = 4'd4;       err = 1'b0; end
      SEG_5:     begin code = 4'd5;       err = 1'b0; end
      SEG_6:     begin code = 4'd6;       err = 1'b0; end
      SEG_7:     begin code = 4'd7;       err = 1'b0; end
      SEG_8:     begin code = 4'd8;       err = 1'b0; end
      SEG_9:     begin code = 4'd9;       err = 1'b0; end
      SEG_BLANK: begin code = CODE_BLANK; err = 1'b0; end
      default:   begin code = CODE_ERR;   err = 1'b1; end
    endcase
  end

endmodule : seg7_decode
`default_nettype wire

// File: rtl/seg7_to_bcd_capture.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : seg7_to_bcd_capture
// Purpose  : Captures a time-multiplexed 7-segment display bus and recovers
//            the BCD value of each digit. A digit is accepted only after
//            STABLE_CNT identical samples. A frame is complete when every
//            digit has been accepted. Complete frames are passed downstream
//            through a single-entry valid/ready buffer.
// Ports    : clk          in   1             rising-edge clock
//            rst_n        in   1             async active-low reset
//            strobe       in   1             sample enable
//            seg_in       in   7             segment lines {a..g}
//            dig_sel      in   NUM_DIGITS    one-hot digit select
//            bcd_out      out  4*NUM_DIGITS  held frame, digit i at [4i+3:4i]
//            err_out      out  NUM_DIGITS    per-digit invalid-pattern flag
//            frame_valid  out  1             bcd_out/err_out hold a frame
//            frame_ready  in   1             downstream accepts the frame
//            overrun      out  1             pulse: a complete frame was dropped
//            sel_err      out  1             pulse: strobe with bad dig_sel
// Revision : 1.0 - initial release
// ============================================================================
module seg7_to_bcd_capture
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int STABLE_CNT = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      strobe,
  input  logic [6:0]                seg_in,
  input  logic [NUM_DIGITS-1:0]     dig_sel,
  output logic [4*NUM_DIGITS-1:0]   bcd_out,
  output logic [NUM_DIGITS-1:0]     err_out,
  output logic                      frame_valid,
  input  logic                      frame_ready,
  output logic                      overrun,
  output logic                      sel_err
);

  localparam logic [3:0]            STABLE  = 4'(STABLE_CNT);
  localparam logic [NUM_DIGITS-1:0] SEL_ONE = NUM_DIGITS'(1);

  // ---------------------------------------------------------------------
  // Decode the shared segment bus once. Every digit slice uses the result.
  // ---------------------------------------------------------------------
  logic [3:0] dec_code;
  logic       dec_err;

  seg7_decode u_decode (
    .seg  (seg_in),
    .code (dec_code),
    .err  (dec_err)
  );

  // Exactly one bit set: the value is nonzero, and clearing its lowest set
  // bit leaves zero.
  logic sel_onehot;
  logic sample_ok;
  logic bad_sel;

  assign sel_onehot = (dig_sel != '0) && ((dig_sel & (dig_sel - SEL_ONE)) == '0);
  assign sample_ok  = strobe &  sel_onehot;
  assign bad_sel    = strobe & ~sel_onehot;

  // ---------------------------------------------------------------------
  // Per-digit stability tracking.
  // ---------------------------------------------------------------------
  logic [4*NUM_DIGITS-1:0] comm_bcd;
  logic [NUM_DIGITS-1:0]   comm_err;
  logic [NUM_DIGITS-1:0]   commit;

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    logic [3:0] cand_code;
    logic       cand_err;
    logic [3:0] cnt;
    logic [3:0] comm_code_r;
    logic       comm_err_r;
    logic       hit;
    logic       match;
    logic [3:0] cnt_next;

    assign hit   = sample_ok & dig_sel[i];
    assign match = (dec_code == cand_code) && (dec_err == cand_err);

    always_comb begin
      cnt_next = 4'd1;
      if (match) begin
        cnt_next = (cnt >= STABLE) ? STABLE : cnt + 4'd1;
      end
    end

    // Commit only when the counter reaches STABLE on this sample. A
    // candidate that has already saturated does not commit again. A new
    // candidate commits at once when STABLE is 1.
    assign commit[i] = hit && (cnt_next == STABLE) && !(match && (cnt == STABLE));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cand_code   <= CODE_BLANK;
        cand_err    <= 1'b0;
        cnt         <= 4'd0;
        comm_code_r <= CODE_BLANK;
        comm_err_r  <= 1'b0;
      end else if (hit) begin
        cand_code <= dec_code;
        cand_err  <= dec_err;
        cnt       <= cnt_next;
        if (commit[i]) begin
          comm_code_r <= dec_code;
          comm_err_r  <= dec_err;
        end
      end
    end

    assign comm_bcd[4*i +: 4] = comm_code_r;
    assign comm_err[i]        = comm_err_r;
  end

  // ---------------------------------------------------------------------
  // Frame assembly. A full seen vector offers the committed values to the
  // output buffer and starts a new frame on the same edge. A commit on
  // that edge already counts toward the next frame.
  // ---------------------------------------------------------------------
  logic [NUM_DIGITS-1:0] seen;
  logic                  offer;

  assign offer = &seen;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seen <= '0;
    end else begin
      seen <= (offer ? '0 : seen) | commit;
    end
  end

  // ---------------------------------------------------------------------
  // Output buffer FSM.
  // ---------------------------------------------------------------------
  out_state_t state;
  out_state_t state_next;
  logic       load;
  logic       ovr_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    ovr_next   = 1'b0;
    case (state)
      EMPTY: begin
        if (offer) begin
          load       = 1'b1;
          state_next = FULL;
        end
      end
      FULL: begin
        if (frame_ready) begin
          // The held frame leaves on this edge. A frame offered on the
          // same edge takes its place.
          if (offer) begin
            load = 1'b1;
          end else begin
            state_next = EMPTY;
          end
        end else if (offer) begin
          ovr_next = 1'b1;
        end
      end
      default: begin
        state_next = EMPTY;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcd_out <= '0;
      err_out <= '0;
      overrun <= 1'b0;
      sel_err <= 1'b0;
    end else begin
      overrun <= ovr_next;
      sel_err <= bad_sel;
      if (load) begin
        bcd_out <= comm_bcd;
        err_out <= comm_err;
      end
    end
  end

  assign frame_valid = (state == FULL);

endmodule : seg7_to_bcd_capture
`default_nettype wire

// File: tb/tb_seg7_to_bcd_capture.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_seg7_to_bcd_capture
// Purpose  : Directed self-checking bench for seg7_to_bcd_capture with
//            NUM_DIGITS=4 and STABLE_CNT=3. The stimulus queues the
//            expected frames. A negedge monitor pops and compares one frame
//            on every valid/ready handshake.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg7_to_bcd_capture;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        strobe;
  logic [6:0]  seg_in;
  logic [3:0]  dig_sel;
  logic [15:0] bcd_out;
  logic [3:0]  err_out;
  logic        frame_valid;
  logic        frame_ready;
  logic        overrun;
  logic        sel_err;

  typedef struct packed {
    logic [15:0] bcd;
    logic [3:0]  err;
  } frame_t;

  frame_t exp_q[$];
  frame_t got;
  int     checks  = 0;
  int     passes  = 0;
  int     ovr_cnt = 0;
  int     sel_cnt = 0;

  always #5 clk = ~clk;

  seg7_to_bcd_capture #(
    .NUM_DIGITS (4),
    .STABLE_CNT (3)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .strobe      (strobe),
    .seg_in      (seg_in),
    .dig_sel     (dig_sel),
    .bcd_out     (bcd_out),
    .err_out     (err_out),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .overrun     (overrun),
    .sel_err     (sel_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Drive n back-to-back strobes for one digit. Inputs change 1ns after an
  // edge and are sampled on the next edge.
  task automatic put(input int d, input logic [6:0] seg, input int n);
    for (int k = 0; k < n; k++) begin
      dig_sel = 4'(1 << d);
      seg_in  = seg;
      strobe  = 1'b1;
      @(posedge clk); #1;
    end
    strobe  = 1'b0;
    dig_sel = 4'b0000;
  endtask

  task automatic bad_strobe(input logic [3:0] sel, input logic [6:0] seg);
    dig_sel = sel;
    seg_in  = seg;
    strobe  = 1'b1;
    @(posedge clk); #1;
    strobe  = 1'b0;
    dig_sel = 4'b0000;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (rst_n) begin
      if (overrun) ovr_cnt++;
      if (sel_err) sel_cnt++;
      if (frame_valid && frame_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_frame: got bcd %h err %h, expected no frame", bcd_out, err_out);
        end else begin
          got = exp_q.pop_front();
          check("frame_bcd", 32'(bcd_out), 32'(got.bcd));
          check("frame_err", 32'(err_out), 32'(got.err));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n       = 1'b0;
    strobe      = 1'b0;
    seg_in      = 7'h00;
    dig_sel     = 4'b0000;
    frame_ready = 1'b1;
    #12;
    check("rst_bcd",     32'(bcd_out),     32'h0);
    check("rst_err",     32'(err_out),     32'h0);
    check("rst_valid",   32'(frame_valid), 32'h0);
    check("rst_overrun", 32'(overrun),     32'h0);
    check("rst_sel_err", 32'(sel_err),     32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(2);

    // Frame A: 0,1,2,3. The frame loads one edge after the last commit.
    exp_q.push_back({16'h3210, 4'h0});
    put(0, 7'h7E, 3); put(1, 7'h30, 3); put(2, 7'h6D, 3); put(3, 7'h79, 3);
    check("A_valid_early", 32'(frame_valid), 32'h0);
    @(posedge clk); #1;
    check("A_valid_rise", 32'(frame_valid), 32'h1);
    idle(3);

    // Frame B: digit 1 holds the saturated 1, then switches to a stable 5.
    exp_q.push_back({16'h7856, 4'h0});
    put(0, 7'h5F, 3); put(1, 7'h30, 2); put(1, 7'h5B, 3);
    put(2, 7'h7F, 3); put(3, 7'h70, 3);
    idle(4);

    // Frame C: digit 2 has an invalid pattern and digit 3 is blank.
    exp_q.push_back({16'hFE49, 4'h4});
    put(0, 7'h7B, 3); put(1, 7'h33, 3); put(2, 7'h01, 3); put(3, 7'h00, 3);
    idle(4);

    // Frame D is held with frame_ready low. Frame E is then dropped.
    frame_ready = 1'b0;
    exp_q.push_back({16'h4321, 4'h0});
    put(0, 7'h30, 3); put(1, 7'h6D, 3); put(2, 7'h79, 3); put(3, 7'h33, 3);
    idle(3);
    check("D_held_valid", 32'(frame_valid), 32'h1);
    check("D_held_bcd",   32'(bcd_out),     32'h4321);
    put(0, 7'h5B, 3); put(1, 7'h7E, 3); put(2, 7'h30, 3); put(3, 7'h7F, 3);
    idle(3);
    check("E_overrun_once", 32'(ovr_cnt), 32'h1);
    check("E_held_bcd",     32'(bcd_out), 32'h4321);

    // Frame F completes in the same cycle that frame_ready rises.
    exp_q.push_back({16'h5432, 4'h0});
    put(0, 7'h6D, 3); put(1, 7'h79, 3); put(2, 7'h33, 3); put(3, 7'h5B, 3);
    frame_ready = 1'b1;
    @(posedge clk); #1;
    check("F_valid_stays", 32'(frame_valid), 32'h1);
    check("F_loaded_bcd",  32'(bcd_out),     32'h5432);
    idle(3);
    check("F_no_overrun", 32'(ovr_cnt), 32'h1);

    // Frame G: multi-hot strobes of an invalid pattern after digits 1 and 2
    // commit. They must not disturb the digits, and each one pulses sel_err.
    exp_q.push_back({16'h9870, 4'h0});
    put(0, 7'h7E, 3); put(1, 7'h70, 3); put(2, 7'h7F, 3);
    bad_strobe(4'b0110, 7'h01);
    check("G_sel_err_pulse", 32'(sel_err), 32'h1);
    bad_strobe(4'b0110, 7'h01);
    bad_strobe(4'b0110, 7'h01);
    put(3, 7'h7B, 3);
    check("G_sel_err_clear", 32'(sel_err), 32'h0);
    bad_strobe(4'b0000, 7'h7E);
    idle(4);

    // Frame I is held. Two digits of the next frame commit, then reset
    // arrives asynchronously and discards everything.
    frame_ready = 1'b0;
    put(0, 7'h33, 3); put(1, 7'h5B, 3); put(2, 7'h5F, 3); put(3, 7'h70, 3);
    idle(3);
    check("I_held_bcd", 32'(bcd_out), 32'h7654);
    put(0, 7'h7F, 3); put(1, 7'h7B, 3);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_bcd",   32'(bcd_out),     32'h0);
    check("async_rst_err",   32'(err_out),     32'h0);
    check("async_rst_valid", 32'(frame_valid), 32'h0);
    exp_q.delete();
    @(posedge clk); #1;
    rst_n       = 1'b1;
    frame_ready = 1'b1;

    // Frame J needs all four digits again after the reset.
    exp_q.push_back({16'h6521, 4'h0});
    put(0, 7'h30, 3); put(1, 7'h6D, 3);
    idle(4);
    check("J_partial_no_valid", 32'(frame_valid), 32'h0);
    put(2, 7'h5B, 3); put(3, 7'h5F, 3);
    check("J_valid_early", 32'(frame_valid), 32'h0);
    @(posedge clk); #1;
    check("J_valid_rise", 32'(frame_valid), 32'h1);
    idle(4);

    check("queue_drained",   32'(exp_q.size()), 32'h0);
    check("overrun_total",   32'(ovr_cnt),      32'h1);
    check("sel_err_total",   32'(sel_cnt),      32'h4);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule : tb_seg7_to_bcd_capture
`default_nettype wire
